// File: rtl/mrisc_ctrl_pkg.sv
// Shared encodings for the KGP-miniRISC multi-cycle control unit.
// Imported by the control FSM, the decoder, data_path and benches.
package mrisc_ctrl_pkg;

  localparam int OPW  = 6;
  localparam int ALUW = 4;
  localparam int BRW  = 5;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    CL_ALU,
    CL_LW,
    CL_SW,
    CL_BR,
    CL_HALT
  } cls_t;

  localparam logic [OPW-1:0] OP_RTYPE = 6'd0;
  localparam logic [OPW-1:0] OP_ADDI  = 6'd1;
  localparam logic [OPW-1:0] OP_COMPI = 6'd2;
  localparam logic [OPW-1:0] OP_LW    = 6'd3;
  localparam logic [OPW-1:0] OP_SW    = 6'd4;
  localparam logic [OPW-1:0] OP_B     = 6'd5;
  localparam logic [OPW-1:0] OP_BR    = 6'd6;
  localparam logic [OPW-1:0] OP_BLTZ  = 6'd7;
  localparam logic [OPW-1:0] OP_BZ    = 6'd8;
  localparam logic [OPW-1:0] OP_BNZ   = 6'd9;
  localparam logic [OPW-1:0] OP_BL    = 6'd10;
  localparam logic [OPW-1:0] OP_BCY   = 6'd11;
  localparam logic [OPW-1:0] OP_BNCY  = 6'd12;
  localparam logic [OPW-1:0] OP_HALT  = 6'd63;

  localparam logic [OPW-1:0] FUNC_MAX = 6'd10;

  localparam logic [ALUW-1:0] ALU_ADD   = 4'd0;
  localparam logic [ALUW-1:0] ALU_COMP  = 4'd1;
  localparam logic [ALUW-1:0] ALU_AND   = 4'd2;
  localparam logic [ALUW-1:0] ALU_XOR   = 4'd3;
  localparam logic [ALUW-1:0] ALU_SHLL  = 4'd4;
  localparam logic [ALUW-1:0] ALU_SHRL  = 4'd5;
  localparam logic [ALUW-1:0] ALU_SHLLV = 4'd6;
  localparam logic [ALUW-1:0] ALU_SHRLV = 4'd7;
  localparam logic [ALUW-1:0] ALU_SHRA  = 4'd8;
  localparam logic [ALUW-1:0] ALU_SHRAV = 4'd9;
  localparam logic [ALUW-1:0] ALU_DIFF  = 4'd10;

  localparam logic [BRW-1:0] BR_NONE = 5'd0;
  localparam logic [BRW-1:0] BR_B    = 5'd1;
  localparam logic [BRW-1:0] BR_BR   = 5'd2;
  localparam logic [BRW-1:0] BR_BLTZ = 5'd3;
  localparam logic [BRW-1:0] BR_BZ   = 5'd4;
  localparam logic [BRW-1:0] BR_BNZ  = 5'd5;
  localparam logic [BRW-1:0] BR_BL   = 5'd6;
  localparam logic [BRW-1:0] BR_BCY  = 5'd7;
  localparam logic [BRW-1:0] BR_BNCY = 5'd8;

  localparam logic [1:0] REGW_NONE = 2'b00;
  localparam logic [1:0] REGW_RS   = 2'b01;
  localparam logic [1:0] REGW_LINK = 2'b10;

  localparam logic [1:0] WBSEL_DMEM = 2'b00;
  localparam logic [1:0] WBSEL_PC4  = 2'b01;
  localparam logic [1:0] WBSEL_ALU  = 2'b10;

  typedef struct packed {
    logic            imm_mux;
    logic            alu_mux;
    logic [ALUW-1:0] alu_op;
    logic [1:0]      wb_sel;
    logic [BRW-1:0]  br_op;
    logic [1:0]      regw;
  } ctrl_t;

endpackage

// File: rtl/mrisc_decode.sv
// Combinational opcode/func decoder producing the control bundle,
// instruction class and an illegal flag for the control FSM.
module mrisc_decode
  import mrisc_ctrl_pkg::*;
(
  input  logic [OPW-1:0] opcode,
  input  logic [OPW-1:0] func,
  output ctrl_t          ctrl,
  output cls_t           cls,
  output logic           illegal
);

  always_comb begin
    ctrl    = '0;
    cls     = CL_ALU;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        if (func > FUNC_MAX) begin
          illegal = 1'b1;
        end else begin
          ctrl.alu_op = func[ALUW-1:0];
          ctrl.wb_sel = WBSEL_ALU;
          ctrl.regw   = REGW_RS;
        end
      end
      OP_ADDI, OP_COMPI: begin
        ctrl.alu_mux = 1'b1;
        ctrl.alu_op  = (opcode == OP_COMPI) ? ALU_COMP : ALU_ADD;
        ctrl.wb_sel  = WBSEL_ALU;
        ctrl.regw    = REGW_RS;
      end
      OP_LW: begin
        cls          = CL_LW;
        ctrl.imm_mux = 1'b1;
        ctrl.alu_mux = 1'b1;
        ctrl.wb_sel  = WBSEL_DMEM;
        ctrl.regw    = REGW_RS;
      end
      OP_SW: begin
        cls          = CL_SW;
        ctrl.imm_mux = 1'b1;
        ctrl.alu_mux = 1'b1;
      end
      OP_B, OP_BR, OP_BLTZ, OP_BZ,
      OP_BNZ, OP_BL, OP_BCY, OP_BNCY: begin
        cls = CL_BR;
        // branch codes follow opcode order starting at b = 1
        ctrl.br_op = opcode[BRW-1:0] - 5'd4;
        if (opcode == OP_BL) begin
          ctrl.regw   = REGW_LINK;
          ctrl.wb_sel = WBSEL_PC4;
        end
      end
      OP_HALT: cls = CL_HALT;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mrisc_control_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer driving the
// KGP-miniRISC data_path control inputs.
module mrisc_control_fsm
  import mrisc_ctrl_pkg::*;
#(
  parameter int OPW  = 6,
  parameter int ALUW = 4,
  parameter int BRW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OPW-1:0]  opcode,
  input  logic [OPW-1:0]  func,
  output logic            ir_write,
  output logic            pc_write,
  output logic [1:0]      reg_write,
  output logic            imm_mux_ctrl,
  output logic            alu_mux_ctrl,
  output logic [ALUW-1:0] alu_op,
  output logic            dmem_enable,
  output logic            dmem_write_enable,
  output logic [1:0]      reg_write_mux_ctrl,
  output logic [BRW-1:0]  br_op,
  output logic            halted,
  output logic            illegal
);

  state_t state, state_nx;
  ctrl_t  dec, held;
  cls_t   dec_cls, held_cls;
  logic   dec_illegal;

  mrisc_decode u_decode (
    .opcode  (opcode),
    .func    (func),
    .ctrl    (dec),
    .cls     (dec_cls),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      held     <= '0;
      held_cls <= CL_ALU;
    end else begin
      state <= state_nx;
      if (state == S_DECODE && state_nx == S_EXEC) begin
        held     <= dec;
        held_cls <= dec_cls;
      end else if (state_nx == S_FETCH) begin
        held     <= '0;
        held_cls <= CL_ALU;
      end
    end
  end

  always_comb begin
    state_nx          = state;
    ir_write          = 1'b0;
    pc_write          = 1'b0;
    reg_write         = REGW_NONE;
    dmem_enable       = 1'b0;
    dmem_write_enable = 1'b0;
    halted            = 1'b0;
    illegal           = 1'b0;
    case (state)
      S_FETCH: begin
        ir_write = 1'b1;
        state_nx = S_DECODE;
      end
      S_DECODE: begin
        if (dec_cls == CL_HALT) begin
          state_nx = S_HALT;
        end else if (dec_illegal) begin
          illegal  = 1'b1;
          pc_write = 1'b1;
          state_nx = S_FETCH;
        end else begin
          state_nx = S_EXEC;
        end
      end
      S_EXEC: begin
        case (held_cls)
          CL_LW, CL_SW: state_nx = S_MEM;
          CL_BR: begin
            pc_write  = 1'b1;
            reg_write = held.regw;
            state_nx  = S_FETCH;
          end
          default: state_nx = S_WB;
        endcase
      end
      S_MEM: begin
        dmem_enable = 1'b1;
        if (held_cls == CL_SW) begin
          dmem_write_enable = 1'b1;
          pc_write          = 1'b1;
          state_nx          = S_FETCH;
        end else begin
          state_nx = S_WB;
        end
      end
      S_WB: begin
        reg_write   = held.regw;
        pc_write    = 1'b1;
        dmem_enable = (held_cls == CL_LW);
        state_nx    = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: state_nx = S_FETCH;
    endcase
    // strobes stay quiet for the whole reset cycle, including FETCH
    if (rst) begin
      ir_write          = 1'b0;
      pc_write          = 1'b0;
      reg_write         = REGW_NONE;
      dmem_enable       = 1'b0;
      dmem_write_enable = 1'b0;
      halted            = 1'b0;
      illegal           = 1'b0;
    end
  end

  assign imm_mux_ctrl       = held.imm_mux;
  assign alu_mux_ctrl       = held.alu_mux;
  assign alu_op             = held.alu_op;
  assign reg_write_mux_ctrl = held.wb_sel;
  assign br_op              = held.br_op;

endmodule

// File: tb/tb_mrisc_control_fsm.sv
// Randomized self-checking bench for mrisc_control_fsm against a
// cycle-table reference model of each instruction's output sequence.
module tb_mrisc_control_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, func;
  logic       ir_write, pc_write, imm_mux_ctrl, alu_mux_ctrl;
  logic [1:0] reg_write, reg_write_mux_ctrl;
  logic [3:0] alu_op;
  logic       dmem_enable, dmem_write_enable, halted, illegal;
  logic [4:0] br_op;
  logic [20:0] vec;

  int n_chk  = 0;
  int n_fail = 0;

  mrisc_control_fsm dut (
    .clk                (clk),
    .rst                (rst),
    .opcode             (opcode),
    .func               (func),
    .ir_write           (ir_write),
    .pc_write           (pc_write),
    .reg_write          (reg_write),
    .imm_mux_ctrl       (imm_mux_ctrl),
    .alu_mux_ctrl       (alu_mux_ctrl),
    .alu_op             (alu_op),
    .dmem_enable        (dmem_enable),
    .dmem_write_enable  (dmem_write_enable),
    .reg_write_mux_ctrl (reg_write_mux_ctrl),
    .br_op              (br_op),
    .halted             (halted),
    .illegal            (illegal)
  );

  always #5 clk = ~clk;

  assign vec = {ir_write, pc_write, reg_write, imm_mux_ctrl,
                alu_mux_ctrl, alu_op, dmem_enable,
                dmem_write_enable, reg_write_mux_ctrl, br_op,
                halted, illegal};

  task automatic chk(input string tag, input logic [20:0] got,
                     input logic [20:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit is_alu(input logic [5:0] op, input logic [5:0] fn);
    return (op == 0 && fn <= 10) || op == 1 || op == 2;
  endfunction

  function automatic bit is_br(input logic [5:0] op);
    return op >= 5 && op <= 12;
  endfunction

  function automatic int exp_len(input logic [5:0] op, input logic [5:0] fn);
    if (is_alu(op, fn)) return 4;
    if (op == 3) return 5;
    if (op == 4) return 4;
    if (is_br(op)) return 3;
    return 2;
  endfunction

  function automatic logic [20:0] exp_vec(input logic [5:0] op,
                                          input logic [5:0] fn,
                                          input int k);
    logic irw, pcw, imm, am, de, dw, hl, il;
    logic [1:0] rw, wb;
    logic [3:0] ao;
    logic [4:0] bo;
    bit alu, lw, sw, br, legal;
    int n;
    irw = 0; pcw = 0; imm = 0; am = 0; de = 0; dw = 0; hl = 0; il = 0;
    rw = 0; wb = 0; ao = 0; bo = 0;
    alu = is_alu(op, fn);
    lw = (op == 3);
    sw = (op == 4);
    br = is_br(op);
    legal = alu || lw || sw || br;
    n = exp_len(op, fn);
    if (k == 1) begin
      irw = 1;
    end else if (k == 2) begin
      if (!legal && op != 63) begin
        il = 1;
        pcw = 1;
      end
    end else if (legal) begin
      ao  = (op == 0) ? fn[3:0] : ((op == 2) ? 4'd1 : 4'd0);
      am  = (op != 0) && !br;
      imm = lw || sw;
      wb  = alu ? 2'b10 : ((op == 10) ? 2'b01 : 2'b00);
      bo  = br ? 5'(op - 6'd4) : 5'd0;
      if (k == n) pcw = 1;
      if (alu && k == 4) rw = 2'b01;
      if (lw) begin
        de = (k >= 4);
        if (k == 5) rw = 2'b01;
      end
      if (sw && k == 4) begin
        de = 1;
        dw = 1;
      end
      if (op == 10) rw = 2'b10;
    end
    return {irw, pcw, rw, imm, am, ao, de, dw, wb, bo, hl, il};
  endfunction

  // each cycle starts 1 time unit after posedge; samples at negedge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                       input int k);
    opcode = (k == 2) ? op : 6'($urandom);
    func   = (k == 2) ? fn : 6'($urandom);
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn);
    int n;
    n = exp_len(op, fn);
    for (int k = 1; k <= n; k++) begin
      drive(op, fn, k);
      @(negedge clk);
      chk($sformatf("op%0d/f%0d c%0d", op, fn, k), vec, exp_vec(op, fn, k));
      step();
    end
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    step();
    chk(tag, vec, 21'h0);
    rst = 1'b0;
  endtask

  initial begin
    logic [5:0] op, fn;
    rst = 1'b1;
    opcode = 0;
    func = 0;
    step();
    do_reset("reset");

    run_instr(6'd0, 6'd3);
    run_instr(6'd1, 6'($urandom));
    run_instr(6'd3, 6'($urandom));
    run_instr(6'd4, 6'($urandom));
    run_instr(6'd5, 6'($urandom));
    run_instr(6'd10, 6'($urandom));
    run_instr(6'd21, 6'($urandom));
    run_instr(6'd0, 6'd12);
    run_instr(6'd0, 6'd10);
    run_instr(6'd2, 6'($urandom));

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) < 8) op = 6'($urandom_range(0, 12));
      else op = 6'($urandom_range(13, 62));
      fn = (op == 0) ? 6'($urandom_range(0, 15)) : 6'($urandom);
      run_instr(op, fn);
    end

    // lw interrupted by reset in its MEM cycle
    for (int k = 1; k <= 4; k++) begin
      drive(6'd3, 6'd0, k);
      @(negedge clk);
      chk($sformatf("lwrst c%0d", k), vec, exp_vec(6'd3, 6'd0, k));
      if (k < 4) step();
    end
    do_reset("rst in MEM");
    run_instr(6'd0, 6'd10);

    // halt absorbs everything but reset
    run_instr(6'd63, 6'($urandom));
    for (int k = 0; k < 10; k++) begin
      opcode = 6'($urandom);
      func = 6'($urandom);
      @(negedge clk);
      chk($sformatf("halt c%0d", k), vec, 21'h2);
      step();
    end
    do_reset("rst from HALT");
    run_instr(6'd4, 6'd0);
    run_instr(6'd1, 6'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mrisc_control_fsm.md
Name: mrisc_control_fsm

Overview:
Multi-cycle control unit for the KGP-miniRISC data_path. It consumes opcode_out/func_out from data_path and drives every data_path control input (reg_write, imm_mux_ctrl, alu_mux_ctrl, alu_op, dmem_enable, dmem_write_enable, reg_write_mux_ctrl, br_op), plus ir_write/pc_write strobes. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and sits beside data_path in the top level.

Parameters:
OPW, 6, opcode and func field width
ALUW, 4, alu_op width
BRW, 5, br_op width

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
opcode  in  6  from data_path opcode_out, valid from DECODE onward
func  in  6  from data_path func_out, used only when opcode = 6'b000000
ir_write  out  1  latch instruction register (FETCH only)
pc_write  out  1  commit pc_new to pc (last state of each instruction)
reg_write  out  2  00 none, 01 write rs, 10 write $31 (link)
imm_mux_ctrl  out  1  0 = imm22 zero-ext (addi/compi), 1 = imm16 sign-ext (lw/sw)
alu_mux_ctrl  out  1  0 = rt, 1 = immediate
alu_op  out  4  0 add, 1 comp, 2 and, 3 xor, 4 shll, 5 shrl, 6 shllv, 7 shrlv, 8 shra, 9 shrav, 10 diff
dmem_enable  out  1  data-memory enable
dmem_write_enable  out  1  data-memory write strobe
reg_write_mux_ctrl  out  2  00 dmem data, 01 pc+4 (link), 10 ALU result
br_op  out  5  0 none, 1 b, 2 br, 3 bltz, 4 bz, 5 bnz, 6 bl, 7 bcy, 8 bncy
halted  out  1  high in HALT
illegal  out  1  one-cycle pulse on undefined opcode/func

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. rst=1 at a clock edge -> FETCH, all outputs 0 (including the strobes) on that edge, regardless of state; applies mid-instruction.
- Select outputs (imm_mux, alu_mux, alu_op, reg_write_mux_ctrl, br_op) are registered at the DECODE->EXEC edge and held constant through EXEC/MEM/WB; cleared to 0 on return to FETCH.
- Strobes are single-cycle, state-gated: ir_write in FETCH; reg_write nonzero only in WB (or in EXEC for bl); dmem_write_enable only in MEM for sw; pc_write only in the final state of an instruction.
- FETCH -> DECODE always. DECODE: opcode 111111 -> HALT; undefined opcode, or R-type with func > 10 -> illegal=1, pc_write=1 (skip as nop), -> FETCH; otherwise -> EXEC.
- Opcode map: 000000 R-type, alu_op=func[3:0], alu_mux 0, WB mux 10. 000001 addi (alu 0, alu_mux 1, imm_mux 0). 000010 compi (alu 1, alu_mux 1). 000011 lw. 000100 sw. 000101 b. 000110 br. 000111 bltz. 001000 bz. 001001 bnz. 001010 bl. 001011 bcy. 001100 bncy. 111111 halt.
- Sequences (cycles): ALU/imm F,D,E,W = 4. lw F,D,E,M,W = 5, with dmem_enable high in M and W and WB mux 00. sw F,D,E,M = 4, with dmem_enable + dmem_write_enable in M and pc_write in M. Branches F,D,E = 3, with br_op driven in E and pc_write in E; bl additionally has reg_write=10 and WB mux 01 in E.
- For all branches, data_path evaluates the condition, and pc_write is asserted for taken and not-taken alike.
- HALT: absorbing, all strobes 0, halted=1; only rst exits.
- Outputs are Moore, derived from state plus held registers; no combinational path from opcode/func to strobes except in DECODE (illegal, pc_write).

Decomposition:
- Package mrisc_ctrl_pkg holds the state encoding, opcode localparams, ALU_* and BR_* codes, and the REGW_* / WBSEL_* codes, so data_path and benches share them.
- One sub-module, mrisc_decode: combinational opcode/func -> control bundle plus illegal and class (alu, lw, sw, br, halt). The FSM registers its output.

Test Plan:
- Reset, then xor R-type (op 0, func 3): ir_write in cycle 1; alu_op=3, alu_mux 0, mux 10 from cycle 3; reg_write=01 and pc_write only in cycle 4; back to FETCH in cycle 5.
- addi (op 1) then lw (op 3): addi takes 4 cycles with alu_mux=1 and imm_mux=0. lw takes 5 cycles with imm_mux=1, dmem_enable in cycles 4–5, mux 00, reg_write=01 in cycle 5, dmem_write_enable never high.
- sw (op 4): dmem_enable=dmem_write_enable=1 only in cycle 4, reg_write stays 00, pc_write in cycle 4, next FETCH in cycle 5.
- b (op 5) and bl (op 10): 3 cycles each, br_op=1 and 6 in EXEC with pc_write; bl also has reg_write=10 and mux 01 in EXEC only.
- Illegal op 6'b010101 and R-type func 6'd12: illegal and pc_write pulse in DECODE, no other strobes, FETCH next.
- halt (op 63): halted=1 stays through 10 cycles with no strobes; rst asserted during lw MEM forces FETCH with all outputs 0 on the same edge.
